// File: rtl/button_debouncer_pkg.sv
// button_debouncer_pkg: shared FSM state encoding and default debounce length
package button_debouncer_pkg;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        WAIT_PRESS   = 2'd1,
        PRESSED      = 2'd2,
        WAIT_RELEASE = 2'd3
    } state_t;

    // 5 ms at 50 MHz
    localparam int DEBOUNCE_CYCLES_DEFAULT = 250000;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for one asynchronous pin, resets to 0
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [1:0] sync_q;
    logic [1:0] sync_d;

    assign sync_d = {sync_q[0], d};
    assign q      = sync_q[1];

    // shift the raw pin through two flops to settle metastability
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= sync_d;
    end

endmodule

// File: rtl/button_debouncer.sv
// button_debouncer: synchronise and debounce a push-button into a clean level and edge pulses
module button_debouncer
    import button_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic btnRaw,
    output logic btnClean,
    output logic pressPulse,
    output logic releasePulse
);

    localparam int                   CNT_WIDTH = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic                 btn_in;
    logic                 btn_sync;
    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 clean_q, clean_d;
    logic                 press_q, press_d;
    logic                 release_q, release_d;

    assign btn_in = BTN_ACTIVE_LOW ? ~btnRaw : btnRaw;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_in),
        .q   (btn_sync)
    );

    // next state and counter: counter only runs in the WAIT states, cleared on every transition
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            RELEASED:     if (btn_sync) state_d = WAIT_PRESS;
            WAIT_PRESS:   if (!btn_sync) state_d = RELEASED;
                          else if (cnt_q == CNT_LAST) state_d = PRESSED;
                          else cnt_d = cnt_q + CNT_WIDTH'(1);
            PRESSED:      if (!btn_sync) state_d = WAIT_RELEASE;
            WAIT_RELEASE: if (btn_sync) state_d = PRESSED;
                          else if (cnt_q == CNT_LAST) state_d = RELEASED;
                          else cnt_d = cnt_q + CNT_WIDTH'(1);
        endcase
    end

    // outputs decoded from the upcoming state so they register alongside it
    always_comb begin
        clean_d   = (state_d == PRESSED) || (state_d == WAIT_RELEASE);
        press_d   = (state_q == WAIT_PRESS) && (state_d == PRESSED);
        release_d = (state_q == WAIT_RELEASE) && (state_d == RELEASED);
    end

    // FSM state and debounce counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RELEASED;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // registered outputs; reset drops them immediately so no pulse escapes an aborted change
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clean_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            clean_q   <= clean_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign btnClean     = clean_q;
    assign pressPulse   = press_q;
    assign releasePulse = release_q;

endmodule

// File: tb/tb_button_debouncer.sv
// tb_button_debouncer: vector table plus scoreboard check of the debouncer with DEBOUNCE_CYCLES=4
module tb_button_debouncer;

    import button_debouncer_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btnRaw = 1'b0;
    logic btnClean, pressPulse, releasePulse;

    int ncmp = 0;
    int nfail = 0;
    int nstep = 0;

    typedef struct {
        logic       raw;
        logic [2:0] exp;
    } vec_t;

    vec_t       tbl[$];
    logic [2:0] sb[$];

    int   press_cnt = 0, release_cnt = 0, toggles = 0, viol = 0;
    logic prev_pulse = 1'b0;

    button_debouncer #(.DEBOUNCE_CYCLES(4), .BTN_ACTIVE_LOW(1'b1)) dut (
        .clk          (clk),
        .rst          (rst),
        .btnRaw       (btnRaw),
        .btnClean     (btnClean),
        .pressPulse   (pressPulse),
        .releasePulse (releasePulse)
    );

    always #5 clk = ~clk;

    // pulse bookkeeping mid-cycle: never together, never back to back
    always @(negedge clk) begin
        if (pressPulse && releasePulse) viol++;
        if ((pressPulse || releasePulse) && prev_pulse) viol++;
        if (pressPulse) press_cnt++;
        if (releasePulse) release_cnt++;
        prev_pulse = pressPulse || releasePulse;
    end

    // stand-in for mux_sequencial: advances on each falling btnClean
    always @(negedge btnClean) toggles++;

    function automatic void add(input logic raw, input logic c, input logic p, input logic r, input int n);
        for (int i = 0; i < n; i++) tbl.push_back('{raw: raw, exp: {c, p, r}});
    endfunction

    task automatic check(input string name, input int got, input int want);
        ncmp++;
        if (got != want) begin
            nfail++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    // drive one raw sample just after a negedge, compare outputs 1 ns after the next posedge
    task automatic step(input logic raw, input logic [2:0] exp);
        logic [2:0] want;
        btnRaw = raw;
        sb.push_back(exp);
        @(posedge clk);
        #1;
        want = sb.pop_front();
        ncmp++;
        nstep++;
        if ({btnClean, pressPulse, releasePulse} !== want) begin
            nfail++;
            $display("FAIL step%0d clean/press/release got %b%b%b want %b", nstep, btnClean, pressPulse, releasePulse, want);
        end
        @(negedge clk);
    endtask

    task automatic run_tbl();
        foreach (tbl[i]) step(tbl[i].raw, tbl[i].exp);
        tbl.delete();
    endtask

    initial begin
        int p0, r0, t0;
        @(negedge clk);
        // reset held with the button pressed: everything stays low
        for (int i = 0; i < 3; i++) step(1'b0, 3'b000);
        rst = 1'b0;
        // press accepted six edges after reset release, then a clean release
        add(0, 0, 0, 0, 6); add(0, 1, 1, 0, 1); add(0, 1, 0, 0, 2);
        add(1, 1, 0, 0, 6); add(1, 0, 0, 1, 1); add(1, 0, 0, 0, 3);
        // press bounce: low 3, high 1, low 3, high
        add(0, 0, 0, 0, 3); add(1, 0, 0, 0, 1); add(0, 0, 0, 0, 3); add(1, 0, 0, 0, 6);
        add(0, 0, 0, 0, 6); add(0, 1, 1, 0, 1); add(0, 1, 0, 0, 2);
        // release bounce of 2 cycles
        add(1, 1, 0, 0, 2); add(0, 1, 0, 0, 4);
        // release bounce of 4 cycles: opposite sample lands exactly when the count completes
        add(1, 1, 0, 0, 4); add(0, 1, 0, 0, 5);
        add(1, 1, 0, 0, 6); add(1, 0, 0, 1, 1); add(1, 0, 0, 0, 2);
        run_tbl();
        // reset asserted mid WAIT_PRESS with cnt=2
        for (int i = 0; i < 5; i++) step(1'b0, 3'b000);
        check("pre_rst_cnt", int'(dut.cnt_q), 2);
        rst = 1'b1;
        #1;
        check("rst_state", int'(dut.state_q), int'(RELEASED));
        check("rst_cnt", int'(dut.cnt_q), 0);
        check("rst_outs", int'({btnClean, pressPulse, releasePulse}), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        add(0, 0, 0, 0, 6); add(0, 1, 1, 0, 1); add(0, 1, 0, 0, 1);
        run_tbl();
        // reset while pressed clears the level without waiting for a clock
        rst = 1'b1;
        #1;
        check("rst_async_clean", int'(btnClean), 0);
        @(negedge clk);
        btnRaw = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) step(1'b1, 3'b000);
        // ten button cycles with bounce on every edge
        p0 = press_cnt; r0 = release_cnt; t0 = toggles;
        for (int k = 0; k < 10; k++) begin
            for (int i = 0; i < 12; i++) begin
                btnRaw = (i < 4) ? logic'(i[0]) : 1'b0;
                @(negedge clk);
            end
            for (int i = 0; i < 12; i++) begin
                btnRaw = (i < 4) ? ~logic'(i[0]) : 1'b1;
                @(negedge clk);
            end
        end
        @(negedge clk);
        check("bounce_presses", press_cnt - p0, 10);
        check("bounce_releases", release_cnt - r0, 10);
        check("mux_toggles", toggles - t0, 10);
        check("pulse_overlap_or_adjacent", viol, 0);
        check("final_clean", int'(btnClean), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
